// File: rtl/decoder_nto2n_reg_pkg.sv
// Shared state encoding and one-hot helper for the registered N-to-M decoder.
package decoder_pkg;

    localparam int SEL_MAX_W = 6;
    localparam int MAX_OUT   = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Codes at or beyond n decode to all-zero so callers can slice the low bits.
    function automatic logic [MAX_OUT-1:0] onehot(input logic [SEL_MAX_W-1:0] code, input int n);
        logic [MAX_OUT-1:0] res;
        res = '0;
        if (int'(code) < n) begin
            res = MAX_OUT'(1) << code;
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_nto2n_reg_dwell_counter.sv
// Up-counter with synchronous clear and a terminal-count flag at DWELL-1.
module dwell_counter #(
    parameter int CNT_W = 8,
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/decoder_nto2n_reg.sv
// Registered N-to-M one-hot decoder with enable, dwell timer and range error.
// Optional auto-scan sequencer is built when DECODER_SCAN_EN is defined.
module decoder_nto2n_reg
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int OUT_N = 4,
    parameter int DWELL = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_N-1:0] out,
    output logic             valid,
    output logic             err
`ifdef DECODER_SCAN_EN
    ,
    input  logic             scan_start,
    output logic             scan_busy
`endif
);

    // Scan steps always last at least one cycle, so the shared counter never sees 0.
    localparam int HOLD = (DWELL > 0) ? DWELL : 1;

    state_t             state;
    logic               load_go;
    logic               scan_go;
    logic               in_range;
    logic               cnt_clr;
    logic               cnt_inc;
    logic               cnt_tc;
    logic [MAX_OUT-1:0] oh_full;

    assign oh_full  = onehot(SEL_MAX_W'(sel), OUT_N);
    assign in_range = (int'(sel) < OUT_N);

`ifdef DECODER_SCAN_EN
    logic [SEL_W-1:0] scan_idx;

    assign scan_go = en && scan_start && (state != ST_SCAN);
    assign load_go = en && load && (state != ST_SCAN) && !scan_go;
`else
    assign scan_go = 1'b0;
    assign load_go = en && load;
`endif

    assign cnt_inc = (state != ST_IDLE);
    assign cnt_clr = !en || load_go || scan_go || (state == ST_IDLE) || cnt_tc;

    dwell_counter #(
        .CNT_W(CNT_W),
        .DWELL(HOLD)
    ) u_dwell (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .inc(cnt_inc),
        .tc (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            out   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
`ifdef DECODER_SCAN_EN
            scan_busy <= 1'b0;
            scan_idx  <= '0;
`endif
        end else begin
            err <= 1'b0;
            if (!en) begin
                state <= ST_IDLE;
                out   <= '0;
                valid <= 1'b0;
`ifdef DECODER_SCAN_EN
                scan_busy <= 1'b0;
            end else if (scan_go) begin
                state     <= ST_SCAN;
                out       <= OUT_N'(1);
                valid     <= 1'b1;
                scan_busy <= 1'b1;
                scan_idx  <= '0;
`endif
            end else if (load_go) begin
                // Retrigger writes the new code directly, so out never goes multi-hot.
                if (in_range) begin
                    state <= ST_ACTIVE;
                    out   <= oh_full[OUT_N-1:0];
                    valid <= 1'b1;
                end else begin
                    state <= ST_IDLE;
                    out   <= '0;
                    valid <= 1'b0;
                    err   <= 1'b1;
                end
            end else begin
                case (state)
                    ST_ACTIVE: begin
                        if (DWELL > 0 && cnt_tc) begin
                            state <= ST_IDLE;
                            out   <= '0;
                            valid <= 1'b0;
                        end
                    end
`ifdef DECODER_SCAN_EN
                    ST_SCAN: begin
                        if (cnt_tc) begin
                            if (scan_idx == SEL_W'(OUT_N - 1)) begin
                                state     <= ST_IDLE;
                                out       <= '0;
                                valid     <= 1'b0;
                                scan_busy <= 1'b0;
                            end else begin
                                scan_idx <= scan_idx + 1'b1;
                                out      <= out << 1;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
